// File: rtl/router_pkt_tx_pkg.sv
// router_pkt_tx_pkg
// Shared definitions for the router packet transmitter and the router's
// receive side: header field widths, maximum payload length, the reserved
// destination code and the transmitter state encoding.
package router_pkt_tx_pkg;

  localparam int HDR_DEST_W = 2;
  localparam int HDR_LEN_W  = 6;
  localparam int MAX_LEN    = 63;
  localparam int PTR_W      = HDR_LEN_W;

  localparam logic [HDR_DEST_W-1:0] DEST_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_ERRWAIT,
    S_DONE
  } state_t;

  // Header byte layout: length in the upper six bits, destination below.
  function automatic logic [7:0] hdr_byte(input logic [HDR_LEN_W-1:0]  len,
                                          input logic [HDR_DEST_W-1:0] dest);
    return {len, dest};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if
// Bundles the transmitter's request, source, router-side and status signals.
//   master : transmitter side (drives req_ready, src_ready, pkt_*, done*)
//   slave  : environment side (drives req_*, src_*, busy, err)
interface router_pkt_tx_if;
  import router_pkt_tx_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [HDR_DEST_W-1:0] req_dest;
  logic [HDR_LEN_W-1:0]  req_len;

  logic                  src_valid;
  logic                  src_ready;
  logic [7:0]            src_data;

  logic                  pkt_valid;
  logic [7:0]            pkt_data;
  logic                  busy;
  logic                  err;

  logic                  done;
  logic                  done_err;
  logic                  done_bad_req;

  modport master (
    input  req_valid, req_dest, req_len, src_valid, src_data, busy, err,
    output req_ready, src_ready, pkt_valid, pkt_data, done, done_err, done_bad_req
  );

  modport slave (
    output req_valid, req_dest, req_len, src_valid, src_data, busy, err,
    input  req_ready, src_ready, pkt_valid, pkt_data, done, done_err, done_bad_req
  );

endinterface

// File: rtl/router_pkt_buf.sv
// router_pkt_buf
// Payload buffer: simple dual-port register array, synchronous write,
// asynchronous read. Contents are not reset; every location is written
// before it is read within a packet.
//   clock : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational)
module router_pkt_buf
  import router_pkt_tx_pkg::*;
#(
  parameter int DEPTH = MAX_LEN + 1
) (
  input  logic             clock,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx
// Buffers a whole payload from the local source, then sends header, payload
// and parity to the router input with no gaps, honouring busy, and reports
// the router's parity verdict sampled over ERR_WAIT cycles.
//   clock : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : router_pkt_tx_if.master (request, source, router, status)
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | req_ready high, waiting for a request
// S_LOAD    | src_ready high, filling the buffer and the parity accumulator
// S_HEADER  | header byte on pkt_data, waiting for busy low
// S_PAYLOAD | payload byte on pkt_data, advancing on each busy-low edge
// S_PARITY  | parity byte on pkt_data (pkt_valid low), waiting for busy low
// S_ERRWAIT | sampling err into a sticky flag for ERR_WAIT cycles
// S_DONE    | one-cycle done pulse with status flags
module router_pkt_tx
  import router_pkt_tx_pkg::*;
#(
  parameter int ERR_WAIT = 3
) (
  input  logic            clock,
  input  logic            reset,
  router_pkt_tx_if.master bus
);

  localparam int                WAIT_W    = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ERR_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

  state_t                state_q, state_d;
  logic [HDR_DEST_W-1:0] dest_q, dest_d;
  logic [HDR_LEN_W-1:0]  len_q, len_d;
  logic [7:0]            parity_q, parity_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic                  pkt_valid_q, pkt_valid_d;
  logic [7:0]            pkt_data_q, pkt_data_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  err_flag_q, err_flag_d;
  logic                  bad_flag_q, bad_flag_d;

  logic                  buf_we;
  logic [7:0]            buf_rdata;
  logic                  req_bad;

  assign req_bad = (bus.req_dest == DEST_INVALID) || (bus.req_len == '0);

  // rptr is zeroed at accept, so HEADER reads buffer[0] through the same port
  // that PAYLOAD uses for buffer[rptr].
  router_pkt_buf u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (wptr_q),
    .wdata (bus.src_data),
    .raddr (rptr_q),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    len_d       = len_q;
    parity_d    = parity_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    pkt_valid_d = pkt_valid_q;
    pkt_data_d  = pkt_data_q;
    wait_d      = wait_q;
    err_flag_d  = err_flag_q;
    bad_flag_d  = bad_flag_q;
    buf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          dest_d     = bus.req_dest;
          len_d      = bus.req_len;
          parity_d   = hdr_byte(bus.req_len, bus.req_dest);
          wptr_d     = '0;
          rptr_d     = '0;
          err_flag_d = 1'b0;
          bad_flag_d = req_bad;
          state_d    = req_bad ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        if (bus.src_valid) begin
          buf_we   = 1'b1;
          parity_d = parity_q ^ bus.src_data;
          wptr_d   = wptr_q + PTR_ONE;
          if (wptr_q == (len_q - PTR_ONE)) begin
            pkt_data_d  = hdr_byte(len_q, dest_q);
            pkt_valid_d = 1'b1;
            state_d     = S_HEADER;
          end
        end
      end

      S_HEADER: begin
        if (!bus.busy) begin
          pkt_data_d = buf_rdata;
          rptr_d     = rptr_q + PTR_ONE;
          state_d    = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        if (!bus.busy) begin
          // rptr == len means buffer[len-1] is the byte being consumed now.
          if (rptr_q == len_q) begin
            pkt_data_d  = parity_q;
            pkt_valid_d = 1'b0;
            state_d     = S_PARITY;
          end else begin
            pkt_data_d = buf_rdata;
            rptr_d     = rptr_q + PTR_ONE;
          end
        end
      end

      S_PARITY: begin
        if (!bus.busy) begin
          pkt_data_d = '0;
          err_flag_d = 1'b0;
          wait_d     = WAIT_LOAD;
          state_d    = S_ERRWAIT;
        end
      end

      S_ERRWAIT: begin
        err_flag_d = err_flag_q | bus.err;
        if (wait_q == '0) begin
          state_d = S_DONE;
        end else begin
          wait_d = wait_q - WAIT_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dest_q      <= '0;
      len_q       <= '0;
      parity_q    <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      wait_q      <= '0;
      err_flag_q  <= 1'b0;
      bad_flag_q  <= 1'b0;
    end else begin
      dest_q      <= dest_d;
      len_q       <= len_d;
      parity_q    <= parity_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      wait_q      <= wait_d;
      err_flag_q  <= err_flag_d;
      bad_flag_q  <= bad_flag_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.src_ready    = (state_q == S_LOAD);
  assign bus.pkt_valid    = pkt_valid_q;
  assign bus.pkt_data     = pkt_data_q;
  assign bus.done         = (state_q == S_DONE);
  assign bus.done_err     = (state_q == S_DONE) && err_flag_q;
  assign bus.done_bad_req = (state_q == S_DONE) && bad_flag_q;

endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Packet transmitter that drives the input port of the 1x3 router. It accepts a request (destination, payload length) and the payload bytes from a local source, buffers the whole payload, then sends header, payload and parity on the router input protocol with no gaps. It honours the router's `busy` back-pressure and reports the router's parity-error verdict per packet.

## Interface
Parameters:
- `ERR_WAIT`, 3: number of cycles after parity acceptance during which `err` is sampled.

Ports:
- `clock` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: packet request present.
- `req_ready` out 1: high only in IDLE; request accepted on an edge with `req_valid && req_ready`.
- `req_dest` in 2: destination FIFO, 0..2.
- `req_len` in 6: payload byte count, 1..63.
- `src_valid` in 1: payload byte present.
- `src_ready` out 1: high only in LOAD.
- `src_data` in 8: payload byte.
- `pkt_valid` out 1: router input packet-valid (registered).
- `pkt_data` out 8: router input data byte (registered).
- `busy` in 1: router back-pressure; the byte on `pkt_data` is consumed at an edge where it is presented and `busy==0`.
- `err` in 1: router parity error indication.
- `done` out 1: one-cycle pulse at end of each request.
- `done_err` out 1: valid with `done`; router reported `err` during ERRWAIT.
- `done_bad_req` out 1: valid with `done`; request rejected (`req_dest==3` or `req_len==0`), nothing sent.

## Operation
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, ERRWAIT, DONE.
- IDLE: `req_ready=1`. On accept:
  - Capture dest and len.
  - Parity accumulator = `{len,dest}`.
  - Bad request goes to DONE with `done_bad_req=1`; otherwise go to LOAD with write pointer 0.
- LOAD: `src_ready=1`.
  - Each `src_valid` edge writes `src_data` to buffer[wptr], XORs it into parity and increments `wptr`.
  - `src_valid` gaps stall LOAD indefinitely.
  - On the edge accepting byte `len-1`: `pkt_data<={len,dest}`, `pkt_valid<=1`, go to HEADER.
- HEADER: at the first edge with `busy==0`: `pkt_data<=buffer[0]`, read pointer 1, go to PAYLOAD.
- PAYLOAD: each edge with `busy==0` advances to `buffer[rptr]`.
  - When the last payload byte is consumed: `pkt_data<=parity`, `pkt_valid<=0`, go to PARITY.
- PARITY: at the edge with `busy==0`: `pkt_data<=0`, go to ERRWAIT and clear the err-capture flag.
- ERRWAIT: sample `err` for `ERR_WAIT` cycles into a sticky flag, then go to DONE.
- DONE: `done=1` for exactly one cycle with the status flags, then return to IDLE.
- Parity: 8-bit XOR of header and all payload bytes.
- Counters: 6-bit pointers, no wrap; `len` is at most 63.
- `busy` held high: `pkt_data` and `pkt_valid` remain stable with no timeout.
- `req_valid` outside IDLE and `src_valid` outside LOAD are ignored.
- Reset at any time: state IDLE, pointers 0, flags clear; all outputs take reset values at that edge. The partial packet is abandoned.

## Timing
- Reset values:
  - `pkt_valid=0`, `pkt_data=0`
  - `req_ready=1` (IDLE)
  - `src_ready=0`
  - `done`, `done_err`, `done_bad_req` = 0
- Request accepted at edge T0; continuous source, bytes loaded at T1..Tlen; header visible after edge Tlen.
- With `busy` low throughout: header at Tlen, payload at Tlen+1..T2len, parity at T2len+1.
- `pkt_valid` falls together with parity presentation.
- `done` is asserted `ERR_WAIT+1` cycles after the parity-consume edge.
- Bad request: `done` one cycle after accept.
- Back-to-back: the next request can be accepted the cycle after `done`.

## Structure
- Shared package: state enum, `HDR_DEST_W=2`, `HDR_LEN_W=6`, `MAX_LEN=63`, and the invalid-destination constant `2'b11`. The router's receive side shares these.
- One sub-module, `router_pkt_buf`: 64x8 simple dual-port register array, synchronous write, asynchronous read.
- FSM, pointers, parity and status logic live in the top module.

## Test plan
- dest=1, len=3, bytes A1,B2,C3, `busy=0`:
  - `pkt_data` sequence 0D,A1,B2,C3,DD.
  - `pkt_valid` high for 4 cycles, low on DD.
  - `done` with `done_err=0`.
- Same packet, `busy` high 2 cycles while A1 is presented and 1 cycle on parity: A1 held 3 cycles, DD held 2 cycles, no byte lost or duplicated.
- `req_dest=3` and, separately, `req_len=0`: `done_bad_req=1` one cycle after accept; `pkt_valid` never rises.
- dest=2, len=63 with random `src_valid` gaps: `pkt_valid` stays high for exactly 64 consecutive consumed bytes; parity matches the model.
- `err` pulsed on the 2nd ERRWAIT cycle: `done_err=1`. Next packet without `err`: `done_err=0`.
- `reset` asserted mid-PAYLOAD: next edge `pkt_valid=0`, `pkt_data=0`, `req_ready=1`. A fresh len=1 packet then transmits correctly.
